// File: rtl/uart_word_assembler.sv
// uart_word_assembler
// Collects four UART RX bytes (MSB byte first) into one 32-bit word and
// strobes dato_ready for one cycle when the word is complete. A partial word
// is dropped (frame_error strobe) if the gap between its bytes grows too long,
// so the assembler re-aligns to word boundaries after a lost byte.
//
// state   | meaning
// WAIT_B3 | idle / waiting for byte 3 (bits 31:24), no timeout running
// WAIT_B2 | byte 3 held, waiting for byte 2 (bits 23:16)
// WAIT_B1 | bytes 3..2 held, waiting for byte 1 (bits 15:8)
// WAIT_B0 | bytes 3..1 held, waiting for byte 0 (bits 7:0)
module uart_word_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  dato_rx,
  output logic [31:0] dato,
  output logic        dato_ready,
  output logic        frame_error,
  output logic [1:0]  byte_count
);

  typedef enum logic [3:0] {
    WAIT_B3 = 4'b0001,
    WAIT_B2 = 4'b0010,
    WAIT_B1 = 4'b0100,
    WAIT_B0 = 4'b1000
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  logic [23:0]     r_shift;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;

  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign w_timeout = (r_state != WAIT_B3) && !rx_done && (r_to_cnt == TO_LAST);

  // Inter-byte timer: runs only while a partial word is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (rx_done || (r_state == WAIT_B3) || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Byte-collection FSM with registered word, strobes and byte count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_B3;
      r_shift     <= '0;
      dato        <= '0;
      dato_ready  <= 1'b0;
      frame_error <= 1'b0;
      byte_count  <= 2'd0;
    end else begin
      dato_ready  <= 1'b0;
      frame_error <= 1'b0;
      if (w_timeout) begin
        r_state     <= WAIT_B3;
        r_shift     <= '0;
        byte_count  <= 2'd0;
        frame_error <= 1'b1;
      end else if (rx_done) begin
        case (r_state)
          WAIT_B3: begin
            r_shift[23:16] <= dato_rx;
            r_state        <= WAIT_B2;
            byte_count     <= 2'd1;
          end
          WAIT_B2: begin
            r_shift[15:8] <= dato_rx;
            r_state       <= WAIT_B1;
            byte_count    <= 2'd2;
          end
          WAIT_B1: begin
            r_shift[7:0] <= dato_rx;
            r_state      <= WAIT_B0;
            byte_count   <= 2'd3;
          end
          WAIT_B0: begin
            dato       <= {r_shift, dato_rx};
            dato_ready <= 1'b1;
            r_state    <= WAIT_B3;
            byte_count <= 2'd0;
          end
          default: begin
            r_state    <= WAIT_B3;
            r_shift    <= '0;
            byte_count <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: two instances (default and a short timeout)
// share one stimulus stream; a byte-list model predicts every output each cycle.
module tb_uart_word_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  dato_rx = 8'h00;

  logic [31:0] dato0, dato1;
  logic        rdy0, rdy1, fe0, fe1;
  logic [1:0]  bc0, bc1;

  always #5 clk = ~clk;

  uart_word_assembler u_dut_def (
    .clk(clk), .reset(reset), .rx_done(rx_done), .dato_rx(dato_rx),
    .dato(dato0), .dato_ready(rdy0), .frame_error(fe0), .byte_count(bc0)
  );

  uart_word_assembler #(.TIMEOUT_CYCLES(16), .TO_W(5)) u_dut_to (
    .clk(clk), .reset(reset), .rx_done(rx_done), .dato_rx(dato_rx),
    .dato(dato1), .dato_ready(rdy1), .frame_error(fe1), .byte_count(bc1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: list of bytes held so far, and idle clocks since the last byte.
  int          tmo[2] = '{1000000, 16};
  int          m_n[2];
  int          m_idle[2];
  logic [23:0] m_acc[2];
  logic [31:0] m_dato[2];
  logic        m_rdy[2];
  logic        m_fe[2];
  bit          started = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_n[k] = 0; m_idle[k] = 0; m_acc[k] = '0; m_dato[k] = '0;
        m_rdy[k] = 0; m_fe[k] = 0;
      end else begin
        m_rdy[k] = 0; m_fe[k] = 0;
        if (rx_done) begin
          if (m_n[k] == 3) begin
            m_dato[k] = {m_acc[k], dato_rx};
            m_rdy[k]  = 1;
            m_n[k]    = 0;
          end else begin
            m_acc[k] = {m_acc[k][15:0], dato_rx};
            m_n[k]++;
          end
          m_idle[k] = 0;
        end else if (m_n[k] > 0) begin
          m_idle[k]++;
          if (m_idle[k] == tmo[k]) begin
            m_n[k] = 0; m_idle[k] = 0; m_fe[k] = 1;
          end
        end
      end
    end
    if (reset) started = 1;
  end

  int          rdy_cnt[2] = '{0, 0};
  int          fe_cnt[2] = '{0, 0};
  int          fe1_cyc = 0;
  logic [31:0] pulse_dato[$];
  int          pulse_cyc[$];

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("dato0", dato0, m_dato[0]);
      chk("rdy0", {31'd0, rdy0}, {31'd0, m_rdy[0]});
      chk("fe0", {31'd0, fe0}, {31'd0, m_fe[0]});
      chk("bc0", {30'd0, bc0}, 32'(m_n[0]));
      chk("dato1", dato1, m_dato[1]);
      chk("rdy1", {31'd0, rdy1}, {31'd0, m_rdy[1]});
      chk("fe1", {31'd0, fe1}, {31'd0, m_fe[1]});
      chk("bc1", {30'd0, bc1}, 32'(m_n[1]));
      if (rdy0 && fe0) chk("rdy0_fe0_excl", 32'd1, 32'd0);
      if (rdy1 && fe1) chk("rdy1_fe1_excl", 32'd1, 32'd0);
      if (rdy0 === 1'b1) begin
        rdy_cnt[0]++;
        pulse_dato.push_back(dato0);
        pulse_cyc.push_back(cyc);
      end
      if (rdy1 === 1'b1) rdy_cnt[1]++;
      if (fe0 === 1'b1) fe_cnt[0]++;
      if (fe1 === 1'b1) begin
        fe_cnt[1]++;
        fe1_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_done = 1'b1; dato_rx = b;
    @(negedge clk); rx_done = 1'b0;
  endtask

  int r0, r1, f0, f1, t_bb;
  logic [7:0] w1[4];
  logic [7:0] w5[4];

  initial begin
    w1 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    w5 = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};

    // Reset state
    do_reset();
    idle(1);
    chk("reset_dato", dato0, 32'h0);
    chk("reset_bc", {30'd0, bc1}, 32'd0);

    // Test 1: DEADBEEF with 16 idle clocks between bytes (default timeout)
    do_reset(); idle(1);
    r0 = rdy_cnt[0];
    for (int i = 0; i < 4; i++) begin
      send_byte(w1[i]);
      if (i < 3) idle(15);
    end
    idle(2);
    chk("t1_dato", dato0, 32'hDEADBEEF);
    chk("t1_pulses", 32'(rdy_cnt[0] - r0), 32'd1);
    chk("t1_bc", {30'd0, bc0}, 32'd0);

    // Test 2: eight back-to-back bytes -> two words 4 clocks apart
    do_reset(); idle(1);
    pulse_dato.delete(); pulse_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx_done = 1'b1; dato_rx = 8'(i + 1);
    end
    @(negedge clk); rx_done = 1'b0;
    idle(2);
    chk("t2_npulses", 32'(pulse_dato.size()), 32'd2);
    if (pulse_dato.size() == 2) begin
      chk("t2_word0", pulse_dato[0], 32'h01020304);
      chk("t2_word1", pulse_dato[1], 32'h05060708);
      chk("t2_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);
    end

    // Test 3: timeout after two bytes (short-timeout instance)
    do_reset(); idle(1);
    f1 = fe_cnt[1];
    send_byte(8'hAA);
    send_byte(8'hBB);
    t_bb = cyc;
    idle(20);
    chk("t3_fe_count", 32'(fe_cnt[1] - f1), 32'd1);
    chk("t3_fe_delay", 32'(fe1_cyc - t_bb), 32'd16);
    chk("t3_bc", {30'd0, bc1}, 32'd0);
    chk("t3_dato_kept", dato1, 32'h0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(2);
    chk("t3_realign", dato1, 32'h11223344);

    // Test 4: second byte on the terminal-count cycle is accepted
    do_reset(); idle(1);
    f1 = fe_cnt[1];
    send_byte(8'h5A);
    idle(14);
    send_byte(8'hA5);
    idle(1);
    chk("t4_no_fe", 32'(fe_cnt[1] - f1), 32'd0);
    chk("t4_bc", {30'd0, bc1}, 32'd2);

    // Test 5: reset mid-word, then a fresh word
    do_reset(); idle(1);
    r0 = rdy_cnt[0];
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    do_reset(); idle(1);
    for (int i = 0; i < 3; i++) send_byte(w5[i]);
    idle(1);
    chk("t5_no_early_rdy", 32'(rdy_cnt[0] - r0), 32'd0);
    send_byte(w5[3]);
    idle(2);
    chk("t5_dato", dato0, 32'h9ABCDEF0);
    chk("t5_pulses", 32'(rdy_cnt[0] - r0), 32'd1);

    // Test 6: long idle after reset
    do_reset(); idle(1);
    r0 = rdy_cnt[0]; r1 = rdy_cnt[1]; f0 = fe_cnt[0]; f1 = fe_cnt[1];
    idle(10000);
    chk("t6_fe", 32'(fe_cnt[0] - f0 + fe_cnt[1] - f1), 32'd0);
    chk("t6_rdy", 32'(rdy_cnt[0] - r0 + rdy_cnt[1] - r1), 32'd0);
    chk("t6_dato", dato1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
